// File: rtl/mem_arb_pkg.sv
// Shared state type and grant-selection helper for the SDRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, XFER} state_t;

  localparam int PICK_W = 5;
  localparam int PICK_N = 1 << PICK_W;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Lowest-index high-priority requester first, else round-robin after last.
  function automatic pick_t rr_pick(input logic [PICK_N-1:0] elig,
                                    input logic [PICK_N-1:0] prio,
                                    input logic [PICK_W-1:0] last,
                                    input int                n);
    pick_t p;
    int    j;
    p = '0;
    j = 0;
    for (int i = PICK_N - 1; i >= 0; i--) begin
      if (i < n && elig[i] && prio[i]) begin
        p.found = 1'b1;
        p.idx   = PICK_W'(i);
      end
    end
    if (!p.found) begin
      for (int k = PICK_N - 1; k >= 0; k--) begin
        if (k < n) begin
          j = int'(last) + 1 + k;
          if (j >= n) j = j - n;
          if (j < PICK_N && elig[j]) begin
            p.found = 1'b1;
            p.idx   = PICK_W'(j);
          end
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester indices, one entry per outstanding read burst.
module arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clkSYS,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CNW-1:0] count_q;
  logic           do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr_q];

  always_ff @(posedge clkSYS) begin
    if (do_push) mem[wptr_q] <= din;
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Burst-granular arbiter sharing one SDRAM controller port; read data is steered back by tag.
// state | meaning
// IDLE  | choose next burst owner    XFER | stream BURST words for grant
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int            AN    = 24,
  parameter int            DN    = 16,
  parameter int            IN    = 4,
  parameter int            BURST = 8,
  parameter logic [IN-1:0] PRIO  = IN'(1),
  parameter int            TAGS  = 4
) (
  input  logic                  clkSYS,
  input  logic                  reset,
  input  logic [AN-1:0]         req_addr [IN],
  input  logic [DN-1:0]         req_data [IN],
  input  logic [IN-1:0]         req_wr,
  input  logic [IN-1:0]         req,
  output logic [IN-1:0]         ack,
  output logic [IN-1:0]         valid,
  output logic [AN-1:0]         mem_addr,
  output logic [DN-1:0]         mem_data,
  output logic                  mem_wr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  output logic                  busy,
  output logic [$clog2(IN)-1:0] grant
);
  localparam int            GW        = $clog2(IN);
  localparam int            CW        = $clog2(BURST);
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST - 1);

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q;
  logic [IN-1:0] elig;
  pick_t         pick;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [GW-1:0] fifo_head;

  // Reads need a free tag slot; writes never return data.
  assign elig = req & (req_wr | {IN{~fifo_full}});
  assign pick = rr_pick(PICK_N'(elig), PICK_N'(PRIO), PICK_W'(last_q), IN);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = XFER;
          grant_d = pick.idx[GW-1:0];
          wcnt_d  = '0;
        end
      end
      XFER: begin
        if (mem_ack) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(IN - 1);
      wcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      if (mem_valid && !fifo_empty) rcnt_q <= fifo_pop ? '0 : rcnt_q + 1'b1;
    end
  end

  assign busy     = (state_q == XFER);
  assign mem_req  = busy;
  assign grant    = grant_q;
  assign mem_addr = req_addr[grant_q];
  assign mem_data = req_data[grant_q];
  assign mem_wr   = busy & req_wr[grant_q];

  always_comb begin
    ack          = '0;
    ack[grant_q] = busy & mem_ack;
  end

  always_comb begin
    valid = '0;
    if (mem_valid && !fifo_empty) valid[fifo_head] = 1'b1;
  end

  assign fifo_push = busy & mem_ack & ~req_wr[grant_q] & (wcnt_q == '0);
  assign fifo_pop  = mem_valid & ~fifo_empty & (rcnt_q == LAST_WORD);

  arb_tag_fifo #(
    .W     (GW),
    .DEPTH (TAGS)
  ) u_tag_fifo (
    .clkSYS (clkSYS),
    .reset  (reset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (grant_q),
    .head   (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Protocol checks: requester must hold req for its whole burst; returns need a tag.
  always_ff @(posedge clkSYS) begin
    if (!reset) begin
      assert (!busy || req[grant_q]);
      assert (!(mem_valid && fifo_empty));
      assert (!pick.found || pick.idx < PICK_W'(IN));
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Burst-granular arbiter that shares one SDRAM controller port among IN requesters: TFT scan-out, PPU frame buffer, rectangle fill and memory test. Each grant transfers exactly BURST words. Read data returning from the controller is steered back to the requester that issued the read, using an in-order tag FIFO. The block sits between the client request buses and the single-port memory controller, in the clkSYS domain.

## Interface
Parameters:
- AN, 24, address width
- DN, 16, data width
- IN, 4, number of requesters
- BURST, 8, words per grant (power of two, ≥2)
- PRIO, 4'b0001, bit i set = requester i is high priority (TFT)
- TAGS, 4, outstanding read bursts (tag FIFO depth, power of two)

Ports:
- clkSYS  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_addr[IN]  in  AN  burst base address per requester
- req_data[IN]  in  DN  write data; advances on each ack
- req_wr[IN]  in  1  1 = write burst
- req  in  IN  request, held until the BURST-th ack
- ack  out  IN  per-word accept strobe to requester
- valid  out  IN  read-data strobe per requester
- mem_addr  out  AN  base address of the granted burst
- mem_data  out  DN  write data of the granted requester
- mem_wr  out  1  direction of the granted burst
- mem_req  out  1  burst request to the controller
- mem_ack  in  1  controller accepted one word
- mem_valid  in  1  controller read word valid
- busy  out  1  burst in progress
- grant  out  $clog2(IN)  current or last granted index

## Operation
- FSM states: IDLE, XFER.
- **IDLE:** pick a winner among eligible requesters. Eligible means req[i]=1, and req_wr[i]=1 or the tag FIFO is not full.
  - High-priority eligible requesters win first; the lowest index wins among them.
  - Otherwise round-robin, starting at (last_grant+1) mod IN.
  - On a winner: latch grant, clear the word counter, go to XFER.
  - With no eligible requester, stay in IDLE.
- **XFER:** mem_req=1.
  - mem_addr, mem_data and mem_wr are combinational muxes of the granted requester's signals.
  - ack[grant] = mem_ack. All other ack bits are 0.
  - Each mem_ack increments the word counter (log2(BURST) bits).
  - On the first mem_ack of a read burst, push grant into the tag FIFO.
  - On the ack that completes BURST words, deassert mem_req (registered), update last_grant, and return to IDLE.
- **Read return:** valid[i] = mem_valid & ~fifo_empty & (fifo_head==i).
  - A return counter counts mem_valid pulses. After BURST pulses, pop the FIFO and clear the counter.
  - mem_valid while the FIFO is empty is dropped; an error flag is asserted in simulation only.
- **Simultaneous push and pop:** both take effect and the occupancy is unchanged. A push is never blocked at that point, because eligibility was checked at grant time.
- **Requester drops req mid-burst:** this is illegal. The arbiter still completes BURST acks using the requester's current signals; a simulation assertion fires.
- **reset:** FSM to IDLE, counters 0, FIFO emptied, last_grant = IN-1 (so round-robin starts at index 0). Any in-flight burst is abandoned.

## Timing
- Reset values: mem_req 0, mem_wr 0, busy 0, grant 0, ack 0, valid 0. mem_addr and mem_data follow the grant-0 mux.
- Latency from req rising to mem_req: 1 cycle (IDLE decision registered).
- Back-to-back bursts: exactly 1 idle cycle between the last ack of one burst and mem_req of the next.
- ack and valid are combinational from mem_ack and mem_valid: zero cycles of added latency. Requesters sample them on the same edge.
- busy = (state==XFER).
- Tag FIFO occupancy is updated at the clock edge. The full check in IDLE uses the registered occupancy.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, XFER)
  - function rr_pick(req_eligible, prio, last) returning index and found bit
- Sub-module arb_tag_fifo: synchronous FIFO, width $clog2(IN), depth TAGS. Ports: push, pop, din, head, empty, full.
- The main module holds the FSM, word counter, return counter and output muxes.

## Test plan
- **Single write:** req[3] with wr=1, addr 24'hfa2000; controller acks every cycle. Expect mem_req one cycle after req, 8 ack[3] pulses, mem_addr=24'hfa2000, then mem_req=0 and busy=0.
- **Round-robin:** req[1], req[2] and req[3] all held, PRIO=0. Expect grant order 1,2,3,1,… with one idle cycle between bursts.
- **Priority:** req[0] rises while requester 2 is mid-burst. Requester 2 finishes its 8 words; grant then goes to 0 ahead of a pending req[3].
- **Read routing:** read bursts are granted to 0 then 1; controller returns 16 mem_valid pulses. Expect the first 8 on valid[0] and the next 8 on valid[1]; FIFO empty afterwards.
- **FIFO full:** with TAGS=4, issue 4 reads with no return. A 5th read request is not granted while a concurrent write is granted. After 8 mem_valid pulses the read is granted.
- **Reset mid-burst:** assert reset after the 3rd ack. Next cycle: mem_req=0, ack=0, FIFO empty. The first grant after reset is the lowest requesting index.
